// File: rtl/imm_extend_pipe_pkg.sv
// Shared LEGv8 opcode constants and immediate format codes used by the
// immediate decoder and the pipelined immediate generator.
package imm_extend_pipe_pkg;

  // Format code presented alongside every extended immediate
  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_D    = 3'd1,
    FMT_I    = 3'd2,
    FMT_B    = 3'd3,
    FMT_CB   = 3'd4,
    FMT_IW   = 3'd5
  } fmt_e;

  // D-format opcodes, instruction bits [31:21]
  localparam logic [10:0] OPC_D_LDUR   = 11'h7C2;
  localparam logic [10:0] OPC_D_STUR   = 11'h7C0;
  localparam logic [10:0] OPC_D_LDURSW = 11'h5C4;
  localparam logic [10:0] OPC_D_STURW  = 11'h5C0;
  localparam logic [10:0] OPC_D_LDURH  = 11'h3C2;
  localparam logic [10:0] OPC_D_STURH  = 11'h3C0;
  localparam logic [10:0] OPC_D_LDURB  = 11'h1C2;
  localparam logic [10:0] OPC_D_STURB  = 11'h1C0;
  localparam logic [10:0] OPC_D_LDXR   = 11'h642;
  localparam logic [10:0] OPC_D_STXR   = 11'h640;

  // I-format opcodes, instruction bits [31:22]
  localparam logic [9:0] OPC_I_ADDI  = 10'h244;
  localparam logic [9:0] OPC_I_ADDIS = 10'h2C4;
  localparam logic [9:0] OPC_I_SUBI  = 10'h344;
  localparam logic [9:0] OPC_I_SUBIS = 10'h3C4;
  localparam logic [9:0] OPC_I_ANDI  = 10'h248;
  localparam logic [9:0] OPC_I_ANDIS = 10'h3C8;
  localparam logic [9:0] OPC_I_ORRI  = 10'h2C8;
  localparam logic [9:0] OPC_I_EORI  = 10'h348;

  // IW-format opcodes, instruction bits [31:23]
  localparam logic [8:0] OPC_IW_MOVZ = 9'h1A5;
  localparam logic [8:0] OPC_IW_MOVK = 9'h1E5;

  // CB-format opcodes, instruction bits [31:24]
  localparam logic [7:0] OPC_CB_CBZ   = 8'hB4;
  localparam logic [7:0] OPC_CB_CBNZ  = 8'hB5;
  localparam logic [7:0] OPC_CB_BCOND = 8'h54;

  // B-format opcodes, instruction bits [31:26]
  localparam logic [5:0] OPC_B_B  = 6'h05;
  localparam logic [5:0] OPC_B_BL = 6'h25;

endpackage

// File: rtl/imm_extend_pipe_decode.sv
// Combinational LEGv8 immediate decoder: instruction word in, extended
// immediate, format code and illegal flag out. The MOVZ/MOVK wide-immediate
// path and its shifter exist only when IMM_IW_EN is defined.
module imm_decode_comb
  import imm_extend_pipe_pkg::*;
#(
  parameter int DATA_WIDTH = 64
) (
  input  logic [31:0]           iInstr,
  output logic [DATA_WIDTH-1:0] oImm,
  output fmt_e                  oFormat,
  output logic                  oIllegal
);

  logic [63:0] w_full;
  fmt_e        w_fmt;
  logic        w_ill;

`ifdef IMM_IW_EN
  logic [63:0] w_iwShifted;
  logic        w_iwOverflow;

  assign w_iwShifted  = {48'b0, iInstr[20:5]} << {iInstr[22:21], 4'b0000};
  assign w_iwOverflow = ((int'(iInstr[22:21]) + 1) * 16) > DATA_WIDTH;
`endif

  // Widest opcode field is tested first so longer encodings shadow shorter ones
  always_comb begin
    w_full = '0;
    w_fmt  = FMT_NONE;
    w_ill  = 1'b1;
    if (iInstr[31:21] inside {OPC_D_LDUR, OPC_D_STUR, OPC_D_LDURSW, OPC_D_STURW,
                              OPC_D_LDURH, OPC_D_STURH, OPC_D_LDURB, OPC_D_STURB,
                              OPC_D_LDXR, OPC_D_STXR}) begin
      w_full = {{55{iInstr[20]}}, iInstr[20:12]};
      w_fmt  = FMT_D;
      w_ill  = 1'b0;
    end else if (iInstr[31:22] inside {OPC_I_ADDI, OPC_I_ADDIS, OPC_I_SUBI, OPC_I_SUBIS,
                                       OPC_I_ANDI, OPC_I_ANDIS, OPC_I_ORRI, OPC_I_EORI}) begin
      w_full = {52'b0, iInstr[21:10]};
      w_fmt  = FMT_I;
      w_ill  = 1'b0;
`ifdef IMM_IW_EN
    end else if (iInstr[31:23] inside {OPC_IW_MOVZ, OPC_IW_MOVK}) begin
      w_fmt = FMT_IW;
      if (w_iwOverflow) begin
        w_full = '0;
        w_ill  = 1'b1;
      end else begin
        w_full = w_iwShifted;
        w_ill  = 1'b0;
      end
`endif
    end else if (iInstr[31:24] inside {OPC_CB_CBZ, OPC_CB_CBNZ, OPC_CB_BCOND}) begin
      w_full = {{43{iInstr[23]}}, iInstr[23:5], 2'b00};
      w_fmt  = FMT_CB;
      w_ill  = 1'b0;
    end else if (iInstr[31:26] inside {OPC_B_B, OPC_B_BL}) begin
      w_full = {{36{iInstr[25]}}, iInstr[25:0], 2'b00};
      w_fmt  = FMT_B;
      w_ill  = 1'b0;
    end
  end

  // Bits above the configured width are dropped on narrow builds
  if (DATA_WIDTH < 64) begin : g_trim
    logic w_unusedHigh;
    assign w_unusedHigh = ^w_full[63:DATA_WIDTH];
  end

  assign oImm     = w_full[DATA_WIDTH-1:0];
  assign oFormat  = w_fmt;
  assign oIllegal = w_ill;

endmodule

// File: rtl/imm_extend_pipe.sv
// Pipelined LEGv8 immediate generator: decodes at acceptance, then carries
// the result through LATENCY valid/ready stages with flush. Wide-immediate
// (MOVZ/MOVK) decoding is enabled by defining IMM_IW_EN.
module imm_extend_pipe
  import imm_extend_pipe_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int LATENCY    = 2
) (
  input  logic                  iCLK,
  input  logic                  iRST,
  input  logic                  iFlush,
  input  logic                  iValid,
  output logic                  oReady,
  input  logic [31:0]           iInstr,
  output logic                  oValid,
  input  logic                  iReady,
  output logic [DATA_WIDTH-1:0] oImmediateExtended,
  output logic [2:0]            oFormat,
  output logic                  oIllegal
);

  logic [DATA_WIDTH-1:0] w_decImm;
  fmt_e                  w_decFmt;
  logic                  w_decIll;

  logic [LATENCY-1:0]    r_valid;
  logic [DATA_WIDTH-1:0] r_imm [LATENCY];
  fmt_e                  r_fmt [LATENCY];
  logic                  r_ill [LATENCY];

  logic [LATENCY-1:0]    w_adv;
  logic [LATENCY-1:0]    w_load;

  imm_decode_comb #(.DATA_WIDTH(DATA_WIDTH)) u_decode (
    .iInstr   (iInstr),
    .oImm     (w_decImm),
    .oFormat  (w_decFmt),
    .oIllegal (w_decIll)
  );

  // Advance ripples back from the consumer; a stage can load when empty or draining
  always_comb begin
    w_adv = '0;
    w_adv[LATENCY-1] = r_valid[LATENCY-1] && iReady;
    for (int k = LATENCY - 2; k >= 0; k--) begin
      w_adv[k] = r_valid[k] && (!r_valid[k+1] || w_adv[k+1]);
    end
    w_load = ~r_valid | w_adv;
  end

  assign oReady = w_load[0] && !iRST && !iFlush;

  // Stage registers: reset clears everything, flush drops valids only
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_valid <= '0;
      for (int k = 0; k < LATENCY; k++) begin
        r_imm[k] <= '0;
        r_fmt[k] <= FMT_NONE;
        r_ill[k] <= 1'b0;
      end
    end else if (iFlush) begin
      r_valid <= '0;
    end else begin
      if (w_load[0]) begin
        r_valid[0] <= iValid;
        if (iValid) begin
          r_imm[0] <= w_decImm;
          r_fmt[0] <= w_decFmt;
          r_ill[0] <= w_decIll;
        end
      end
      for (int k = 1; k < LATENCY; k++) begin
        if (w_load[k]) begin
          r_valid[k] <= r_valid[k-1];
          if (r_valid[k-1]) begin
            r_imm[k] <= r_imm[k-1];
            r_fmt[k] <= r_fmt[k-1];
            r_ill[k] <= r_ill[k-1];
          end
        end
      end
    end
  end

  assign oValid             = r_valid[LATENCY-1];
  assign oImmediateExtended = r_imm[LATENCY-1];
  assign oFormat            = r_fmt[LATENCY-1];
  assign oIllegal           = r_ill[LATENCY-1];

endmodule
